input_edge_timestamper: RTL and testbench



---
 rtl/input_edge_timestamper_pkg.sv | 32 +++
 rtl/input_edge_timestamper_edge_fifo.sv | 55 +++++
 rtl/input_edge_timestamper.sv | 170 +++++++++++++++++
 tb/tb_input_edge_timestamper.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/input_edge_timestamper_pkg.sv
// Shared definitions for the input edge timestamper and its readout CSR decoder.
// Entry layout, from the LSB up: fine, coarse, multi, polarity.
package input_edge_timestamper_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE    = 2'd0,
    EDGE_RISING  = 2'd1,
    EDGE_FALLING = 2'd2,
    EDGE_BOTH    = 2'd3
  } edgeSel_e;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2
  } tsState_e;

  localparam int ENTRY_FINE_LSB = 0;

  function automatic int entryCoarseLsb(input int fineWidth);
    return fineWidth;
  endfunction

  function automatic int entryMultiBit(input int fineWidth, input int coarseWidth);
    return fineWidth + coarseWidth;
  endfunction

  function automatic int entryPolarityBit(input int fineWidth, input int coarseWidth);
    return fineWidth + coarseWidth + 1;
  endfunction

endpackage

// File: rtl/input_edge_timestamper_edge_fifo.sv
// Single-clock FWFT FIFO holding timestamp entries; the head reads as zero when empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module edge_fifo #(
  parameter int ENTRY_WIDTH        = 28,
  parameter int FIFO_ADDRESS_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wrEn,
  input  logic [ENTRY_WIDTH-1:0] wrData,
  input  logic                   rdEn,
  output logic [ENTRY_WIDTH-1:0] rdData,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 1 << FIFO_ADDRESS_WIDTH;
  localparam logic [FIFO_ADDRESS_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [FIFO_ADDRESS_WIDTH:0]   CNT_ONE = 1;
  localparam logic [FIFO_ADDRESS_WIDTH:0]   CNT_FULL = DEPTH[FIFO_ADDRESS_WIDTH:0];

  logic [ENTRY_WIDTH-1:0]        mem [DEPTH];
  logic [FIFO_ADDRESS_WIDTH-1:0] wrPtr;
  logic [FIFO_ADDRESS_WIDTH-1:0] rdPtr;
  logic [FIFO_ADDRESS_WIDTH:0]   count;
  logic                          doPush;
  logic                          doPop;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign doPop  = rdEn && !empty;
  assign doPush = wrEn && (!full || doPop);
  assign rdData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_edge_timestamper.sv
// Detects the first qualifying pin transition in each SERDES word and queues a
// {polarity, multi, coarse, fine} timestamp relative to the last reference strobe.
module input_edge_timestamper
  import input_edge_timestamper_pkg::*;
#(
  parameter int SERDES_WIDTH       = 4,
  parameter int COARSE_WIDTH       = 24,
  parameter int HOLDOFF_WIDTH      = 16,
  parameter int FIFO_ADDRESS_WIDTH = 4,
  parameter int FINE_WIDTH         = $clog2(SERDES_WIDTH),
  parameter int ENTRY_WIDTH        = 2 + COARSE_WIDTH + FINE_WIDTH
) (
  input  logic                     evrClk,
  input  logic                     evrReset,
  input  logic [SERDES_WIDTH-1:0]  serdesPattern,
  input  logic                     referenceStrobe,
  input  logic                     enable,
  input  logic [1:0]               edgeSelect,
  input  logic [HOLDOFF_WIDTH-1:0] holdoffCount,
  input  logic                     clearOverflow,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [ENTRY_WIDTH-1:0]   outEntry,
  output logic                     overflow,
  output logic [15:0]              dropCount
);

  localparam logic [COARSE_WIDTH-1:0]  COARSE_ONE = 1;
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE   = 1;
  localparam logic [SERDES_WIDTH-1:0]  MASK_ONE   = 1;

  logic [SERDES_WIDTH-1:0] word_p0;
  logic                    prevBit_p0;
  logic                    wordVld_p0;
  logic                    primed_p0;
  logic [COARSE_WIDTH-1:0] coarse_p0;
  logic [1:0]              edgeSel_p0;

  // Stage p0: input word, previous MSB and coarse count of this word
  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      word_p0    <= '0;
      prevBit_p0 <= 1'b0;
      wordVld_p0 <= 1'b0;
      primed_p0  <= 1'b0;
      coarse_p0  <= '0;
      edgeSel_p0 <= '0;
    end else begin
      word_p0    <= serdesPattern;
      prevBit_p0 <= word_p0[SERDES_WIDTH-1];
      wordVld_p0 <= 1'b1;
      primed_p0  <= wordVld_p0;
      edgeSel_p0 <= edgeSelect;
      if (referenceStrobe || !wordVld_p0) coarse_p0 <= '0;
      else if (coarse_p0 != '1)           coarse_p0 <= coarse_p0 + COARSE_ONE;
    end
  end

  logic [SERDES_WIDTH-1:0] prevSamples;
  logic [SERDES_WIDTH-1:0] toggled;
  logic [SERDES_WIDTH-1:0] qualMask;
  logic                    riseEn;
  logic                    fallEn;
  logic                    hit;
  logic                    multi;
  logic                    polarity;
  logic [FINE_WIDTH-1:0]   hitFine;

  assign prevSamples = {word_p0[SERDES_WIDTH-2:0], prevBit_p0};
  assign toggled     = word_p0 ^ prevSamples;
  assign riseEn      = (edgeSel_p0 == EDGE_RISING)  || (edgeSel_p0 == EDGE_BOTH);
  assign fallEn      = (edgeSel_p0 == EDGE_FALLING) || (edgeSel_p0 == EDGE_BOTH);

  always_comb begin
    qualMask = (toggled & word_p0 & {SERDES_WIDTH{riseEn}}) |
               (toggled & ~word_p0 & {SERDES_WIDTH{fallEn}});
    // Bit 0 of the first word has no genuine predecessor sample
    if (!primed_p0) qualMask[0] = 1'b0;
    if (!wordVld_p0) qualMask = '0;
    hitFine = '0;
    for (int i = SERDES_WIDTH - 1; i >= 0; i--) begin
      if (qualMask[i]) hitFine = FINE_WIDTH'(i);
    end
    hit      = |qualMask;
    multi    = (qualMask & (qualMask - MASK_ONE)) != '0;
    polarity = word_p0[hitFine];
  end

  tsState_e                 state;
  logic [HOLDOFF_WIDTH-1:0] holdCnt;
  logic                     accept;
  logic                     push_p1;
  logic [ENTRY_WIDTH-1:0]   entry_p1;

  assign accept = (state == ST_ARMED) && hit;

  // Stage p1: arming/holdoff control and the registered entry headed for the FIFO
  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      state   <= ST_DISABLED;
      holdCnt <= '0;
      push_p1 <= 1'b0;
    end else begin
      push_p1 <= accept;
      if (!enable) begin
        state   <= ST_DISABLED;
        holdCnt <= '0;
      end else begin
        case (state)
          ST_DISABLED: state <= ST_ARMED;
          ST_ARMED: begin
            if (accept && (holdoffCount != '0)) begin
              state   <= ST_HOLDOFF;
              holdCnt <= holdoffCount;
            end
          end
          ST_HOLDOFF: begin
            if (holdCnt <= HOLD_ONE) begin
              state   <= ST_ARMED;
              holdCnt <= '0;
            end else begin
              holdCnt <= holdCnt - HOLD_ONE;
            end
          end
          default: state <= ST_DISABLED;
        endcase
      end
    end
  end

  always_ff @(posedge evrClk) begin
    entry_p1 <= {polarity, multi, coarse_p0, hitFine};
  end

  logic fifoFull;
  logic fifoEmpty;
  logic drop;

  edge_fifo #(
    .ENTRY_WIDTH       (ENTRY_WIDTH),
    .FIFO_ADDRESS_WIDTH(FIFO_ADDRESS_WIDTH)
  ) u_fifo (
    .clk   (evrClk),
    .rst   (evrReset),
    .wrEn  (push_p1),
    .wrData(entry_p1),
    .rdEn  (outReady),
    .rdData(outEntry),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign outValid = !fifoEmpty;
  assign drop     = push_p1 && fifoFull && !outReady;

  // Stage p2: lost-event bookkeeping
  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (clearOverflow) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_input_edge_timestamper.sv
// Directed bench for input_edge_timestamper with hand-computed timestamp entries.
module tb_input_edge_timestamper;

  logic        evrClk = 1'b0;
  logic        evrReset;
  logic [3:0]  serdesPattern;
  logic        referenceStrobe;
  logic        enable;
  logic [1:0]  edgeSelect;
  logic [15:0] holdoffCount;
  logic        clearOverflow;
  logic        outValid;
  logic        outReady;
  logic [27:0] outEntry;
  logic        overflow;
  logic [15:0] dropCount;

  int compared   = 0;
  int mismatched = 0;

  input_edge_timestamper dut (
    .evrClk         (evrClk),
    .evrReset       (evrReset),
    .serdesPattern  (serdesPattern),
    .referenceStrobe(referenceStrobe),
    .enable         (enable),
    .edgeSelect     (edgeSelect),
    .holdoffCount   (holdoffCount),
    .clearOverflow  (clearOverflow),
    .outValid       (outValid),
    .outReady       (outReady),
    .outEntry       (outEntry),
    .overflow       (overflow),
    .dropCount      (dropCount)
  );

  always #5 evrClk = ~evrClk;

  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkEntry(input logic pol, input logic multi,
                                          input logic [23:0] coarse, input logic [1:0] fine);
    return {4'b0, pol, multi, coarse, fine};
  endfunction

  task automatic word(input logic [3:0] p, input logic strobe);
    serdesPattern   = p;
    referenceStrobe = strobe;
    tick();
    referenceStrobe = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [31:0] exp);
    int waited = 0;
    while (!outValid && waited < 20) begin
      tick();
      waited++;
    end
    checkVal({tag, "_vld"}, 32'(outValid), 32'd1);
    if (outValid) begin
      checkVal(tag, 32'(outEntry), exp);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    evrReset = 1'b1; serdesPattern = 4'b1111; referenceStrobe = 1'b0;
    enable = 1'b1; edgeSelect = 2'd3; holdoffCount = 16'd0;
    clearOverflow = 1'b0; outReady = 1'b0;
    tick(); tick();
    checkVal("rst_valid", 32'(outValid), 32'd0);
    checkVal("rst_entry", 32'(outEntry), 32'd0);
    checkVal("rst_ovf", 32'(overflow), 32'd0);
    checkVal("rst_drops", 32'(dropCount), 32'd0);

    // Priming: first word 1111 must not report at bit 0
    evrReset = 1'b0;
    for (int i = 0; i < 6; i++) word(4'b1111, 1'b0);
    checkVal("prime_none", 32'(outValid), 32'd0);

    // Single rising edge at coarse 5, fine 2
    edgeSelect = 2'd1;
    word(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) word(4'b0000, 1'b0);
    serdesPattern = 4'b1100; tick();
    serdesPattern = 4'b0000; tick();
    checkVal("single_lat_k1", 32'(outValid), 32'd0);
    tick();
    checkVal("single_lat_k2", 32'(outValid), 32'd1);
    checkVal("single_entry", 32'(outEntry), mkEntry(1'b1, 1'b0, 24'd5, 2'd2));
    tick();
    checkVal("single_stable", 32'(outEntry), mkEntry(1'b1, 1'b0, 24'd5, 2'd2));
    outReady = 1'b1; tick(); outReady = 1'b0;
    checkVal("single_popped", 32'(outValid), 32'd0);

    // Cross-word falling edge
    edgeSelect = 2'd2;
    word(4'b1000, 1'b1);
    word(4'b0000, 1'b0);
    popCheck("cross", mkEntry(1'b0, 1'b0, 24'd1, 2'd0));
    tick(); tick();
    checkVal("cross_only", 32'(outValid), 32'd0);

    // Multi flag
    edgeSelect = 2'd3;
    word(4'b0101, 1'b1);
    word(4'b0000, 1'b0);
    popCheck("multi", mkEntry(1'b1, 1'b1, 24'd0, 2'd0));
    tick(); tick();
    checkVal("multi_only", 32'(outValid), 32'd0);

    // Holdoff of 3 words
    holdoffCount = 16'd3; edgeSelect = 2'd1;
    word(4'b0000, 1'b1);
    for (int i = 1; i < 8; i++) word((i % 2) ? 4'b0001 : 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) word(4'b0000, 1'b0);
    popCheck("hold_a", mkEntry(1'b1, 1'b0, 24'd1, 2'd0));
    popCheck("hold_b", mkEntry(1'b1, 1'b0, 24'd5, 2'd0));
    tick(); tick(); tick();
    checkVal("hold_only", 32'(outValid), 32'd0);
    holdoffCount = 16'd0;

    // Disabled: edges ignored
    enable = 1'b0;
    word(4'b0000, 1'b0);
    word(4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) word(4'b0000, 1'b0);
    checkVal("disabled_none", 32'(outValid), 32'd0);
    enable = 1'b1;
    word(4'b0000, 1'b0); word(4'b0000, 1'b0);

    // Overflow: 20 events into a 16-deep FIFO
    edgeSelect = 2'd3;
    for (int i = 0; i < 20; i++) word((i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) word(4'b0000, 1'b0);
    checkVal("ovf_flag", 32'(overflow), 32'd1);
    checkVal("ovf_drops", 32'(dropCount), 32'd4);
    checkVal("ovf_valid", 32'(outValid), 32'd1);
    clearOverflow = 1'b1; tick(); clearOverflow = 1'b0;
    checkVal("clr_flag", 32'(overflow), 32'd0);
    checkVal("clr_drops", 32'(dropCount), 32'd0);

    // Push concurrent with pop while full
    serdesPattern = 4'b1111; tick();
    tick();
    outReady = 1'b1; tick(); outReady = 1'b0;
    checkVal("pushpop_flag", 32'(overflow), 32'd0);
    checkVal("pushpop_drops", 32'(dropCount), 32'd0);
    n = 0;
    outReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (outValid) n++;
      tick();
    end
    outReady = 1'b0;
    checkVal("pushpop_drain", 32'(n), 32'd16);

    // Reset mid-stream with three queued entries
    word(4'b0000, 1'b0);
    word(4'b1111, 1'b0);
    word(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) word(4'b0000, 1'b0);
    checkVal("mid_queued", 32'(outValid), 32'd1);
    evrReset = 1'b1; tick();
    checkVal("mid_flushed", 32'(outValid), 32'd0);
    checkVal("mid_entry", 32'(outEntry), 32'd0);
    evrReset = 1'b0; edgeSelect = 2'd1;
    word(4'b0000, 1'b0);
    word(4'b0000, 1'b0);
    word(4'b0001, 1'b0);
    word(4'b0000, 1'b0);
    popCheck("mid_coarse", mkEntry(1'b1, 1'b0, 24'd2, 2'd0));
    tick(); tick();
    checkVal("mid_empty", 32'(outValid), 32'd0);
    checkVal("mid_drops", 32'(dropCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
